// File: rtl/prio_code_expander.sv
// prio_code_expander
// Sequential inverse of the 3-bit leading-one priority decoder. A 2-bit code
// accepted over valid/ready is expanded into three size-bit source words whose
// bit-0 slice {src1[0],src2[0],src3[0]} decodes back to that code. Don't-care
// bits are zero by default, or LFSR fill when PRIO_CODE_EXPANDER_RANDFILL_EN
// is defined. count tracks completed output transfers and wraps at 16 bits.
module prio_code_expander #(
   parameter int unsigned size = 1,
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [1:0]      in_code,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [size-1:0] src1,
   output logic [size-1:0] src2,
   output logic [size-1:0] src3,
   output logic [15:0]     count
);

   localparam int unsigned W    = 3 * size;
   localparam int unsigned POS1 = 2 * size;
   localparam int unsigned POS2 = size;
   localparam int unsigned POS3 = 0;

   logic         accept;
   logic         xfer;
   logic [W-1:0] fill;
   logic [W-1:0] word_c;

   // Handshake: the single output register can take a word whenever it is
   // empty or is being drained this cycle.
   assign in_ready = !out_valid || out_ready;
   assign accept   = in_valid && in_ready;
   assign xfer     = out_valid && out_ready;

`ifdef PRIO_CODE_EXPANDER_RANDFILL_EN
   localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;

   logic [15:0] lfsr;
   logic        lfsr_fb;

   assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

   // Fill vector: flattened bit j takes lfsr[j mod 16].
   always_comb begin
      fill = '0;
      for (int j = 0; j < int'(W); j++) begin
         fill[j] = lfsr[4'(j % 16)];
      end
   end

   // LFSR advances once per accepted code, after its value has been used.
   always_ff @(posedge clk) begin
      if (reset) begin
         lfsr <= SEED_EFF;
      end else if (accept) begin
         lfsr <= {lfsr[14:0], lfsr_fb};
      end
   end
`else
   logic [15:0] seed_unused;

   assign seed_unused = SEED;
   assign fill        = '0;
`endif

   // Overlay the determined bit-0 positions onto the fill vector.
   always_comb begin
      word_c = fill;
      case (in_code)
         2'd0: begin
            word_c[POS1] = 1'b1;
         end
         2'd1: begin
            word_c[POS1] = 1'b0;
            word_c[POS2] = 1'b1;
         end
         2'd2: begin
            word_c[POS1] = 1'b0;
            word_c[POS2] = 1'b0;
            word_c[POS3] = 1'b1;
         end
         default: begin
            word_c[POS1] = 1'b0;
            word_c[POS2] = 1'b0;
            word_c[POS3] = 1'b0;
         end
      endcase
   end

   // Output register and transfer counter; reset drops any pending word.
   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid <= 1'b0;
         src1      <= '0;
         src2      <= '0;
         src3      <= '0;
         count     <= 16'h0000;
      end else begin
         if (accept) begin
            {src1, src2, src3} <= word_c;
            out_valid          <= 1'b1;
         end else if (xfer) begin
            out_valid <= 1'b0;
         end
         if (xfer) begin
            count <= count + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_prio_code_expander.sv
// Testbench for prio_code_expander: directed vectors on a size=3 instance
// (SEED=1) and a randomized handshake run on a size=8 instance.
module tb_prio_code_expander;

   logic       clk = 1'b0;
   logic       reset;

   logic       iv3, ir3, ov3, or3;
   logic [1:0] code3;
   logic [2:0] s1_3, s2_3, s3_3;
   logic [15:0] cnt3;

   logic       iv8, ir8, ov8, or8;
   logic [1:0] code8;
   logic [7:0] s1_8, s2_8, s3_8;
   logic [15:0] cnt8;

   int nvec = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   prio_code_expander #(.size(3), .SEED(16'h0001)) dut3 (
      .clk(clk), .reset(reset),
      .in_valid(iv3), .in_ready(ir3), .in_code(code3),
      .out_valid(ov3), .out_ready(or3),
      .src1(s1_3), .src2(s2_3), .src3(s3_3), .count(cnt3)
   );

   prio_code_expander #(.size(8)) dut8 (
      .clk(clk), .reset(reset),
      .in_valid(iv8), .in_ready(ir8), .in_code(code8),
      .out_valid(ov8), .out_ready(or8),
      .src1(s1_8), .src2(s2_8), .src3(s3_8), .count(cnt8)
   );

   function automatic logic [1:0] lead_one(input logic a, input logic b, input logic c);
      if (a)      return 2'd0;
      else if (b) return 2'd1;
      else if (c) return 2'd2;
      else        return 2'd3;
   endfunction

   task automatic test_reset();
      @(negedge clk);
      reset = 1'b1;
      iv3 = 1'b0; or3 = 1'b1; code3 = 2'd0;
      iv8 = 1'b0; or8 = 1'b1; code8 = 2'd0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      nvec++; if (ov3 !== 1'b0) begin nerr++; $display("FAIL reset_out_valid got %b exp 0", ov3); end
      nvec++; if (ir3 !== 1'b1) begin nerr++; $display("FAIL reset_in_ready got %b exp 1", ir3); end
      nvec++; if ({s1_3, s2_3, s3_3} !== 9'h000) begin nerr++; $display("FAIL reset_src got %h exp 000", {s1_3, s2_3, s3_3}); end
      nvec++; if (cnt3 !== 16'h0000) begin nerr++; $display("FAIL reset_count got %h exp 0000", cnt3); end
      nvec++; if (ov8 !== 1'b0 || cnt8 !== 16'h0000) begin nerr++; $display("FAIL reset_dut8 got ov=%b cnt=%h exp ov=0 cnt=0000", ov8, cnt8); end
   endtask

   // Codes 0..3 back to back straight after reset (LFSR at seed 0x0001).
   task automatic test_back_to_back();
      logic [2:0] e1 [4];
      logic [2:0] e2 [4];
      logic [2:0] e3 [4];
`ifdef PRIO_CODE_EXPANDER_RANDFILL_EN
      e1[0] = 3'b001; e2[0] = 3'b000; e3[0] = 3'b001;
      e1[1] = 3'b000; e2[1] = 3'b001; e3[1] = 3'b010;
      e1[2] = 3'b000; e2[2] = 3'b000; e3[2] = 3'b101;
      e1[3] = 3'b000; e2[3] = 3'b000; e3[3] = 3'b000;
`else
      e1[0] = 3'b001; e2[0] = 3'b000; e3[0] = 3'b000;
      e1[1] = 3'b000; e2[1] = 3'b001; e3[1] = 3'b000;
      e1[2] = 3'b000; e2[2] = 3'b000; e3[2] = 3'b001;
      e1[3] = 3'b000; e2[3] = 3'b000; e3[3] = 3'b000;
`endif
      iv3 = 1'b1; or3 = 1'b1; code3 = 2'd0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         nvec++; if (ov3 !== 1'b1) begin nerr++; $display("FAIL b2b_valid[%0d] got %b exp 1", k, ov3); end
         nvec++; if ({s1_3, s2_3, s3_3} !== {e1[k], e2[k], e3[k]}) begin
            nerr++; $display("FAIL b2b_words[%0d] got %b_%b_%b exp %b_%b_%b", k, s1_3, s2_3, s3_3, e1[k], e2[k], e3[k]);
         end
         nvec++; if (cnt3 !== 16'(k)) begin nerr++; $display("FAIL b2b_count[%0d] got %0d exp %0d", k, cnt3, k); end
         if (k < 3) code3 = 2'(k + 1);
         else       iv3 = 1'b0;
      end
      @(negedge clk);
      nvec++; if (cnt3 !== 16'd4) begin nerr++; $display("FAIL b2b_final_count got %0d exp 4", cnt3); end
      nvec++; if (ov3 !== 1'b0) begin nerr++; $display("FAIL b2b_drained got %b exp 0", ov3); end
   endtask

   // One accept (fifth since reset, LFSR=0x0010), then 5 stalled cycles.
   task automatic test_backpressure();
      logic [8:0] exp_w;
`ifdef PRIO_CODE_EXPANDER_RANDFILL_EN
      exp_w = {3'b000, 3'b010, 3'b001};
`else
      exp_w = {3'b000, 3'b000, 3'b001};
`endif
      iv3 = 1'b1; code3 = 2'd2; or3 = 1'b0;
      @(negedge clk);
      code3 = 2'd1;
      for (int k = 0; k < 5; k++) begin
         nvec++; if (ir3 !== 1'b0) begin nerr++; $display("FAIL bp_in_ready[%0d] got %b exp 0", k, ir3); end
         nvec++; if ({s1_3, s2_3, s3_3} !== exp_w || ov3 !== 1'b1) begin
            nerr++; $display("FAIL bp_hold[%0d] got %b ov=%b exp %b ov=1", k, {s1_3, s2_3, s3_3}, ov3, exp_w);
         end
         nvec++; if (cnt3 !== 16'd4) begin nerr++; $display("FAIL bp_count_hold[%0d] got %0d exp 4", k, cnt3); end
         @(negedge clk);
      end
      iv3 = 1'b0; or3 = 1'b1;
      #1;
      nvec++; if (ir3 !== 1'b1) begin nerr++; $display("FAIL bp_in_ready_release got %b exp 1", ir3); end
      @(negedge clk);
      nvec++; if (cnt3 !== 16'd5 || ov3 !== 1'b0) begin nerr++; $display("FAIL bp_one_xfer got cnt=%0d ov=%b exp cnt=5 ov=0", cnt3, ov3); end
      @(negedge clk);
      nvec++; if (cnt3 !== 16'd5) begin nerr++; $display("FAIL bp_no_extra got %0d exp 5", cnt3); end
   endtask

   // Reset while a word is stalled at the output.
   task automatic test_reset_mid();
      iv3 = 1'b1; code3 = 2'd0; or3 = 1'b0;
      @(negedge clk);
      iv3 = 1'b0;
      nvec++; if (ov3 !== 1'b1) begin nerr++; $display("FAIL rstmid_pending got %b exp 1", ov3); end
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      nvec++; if (ov3 !== 1'b0 || cnt3 !== 16'h0000 || {s1_3, s2_3, s3_3} !== 9'h000) begin
         nerr++; $display("FAIL rstmid_clear got ov=%b cnt=%h src=%h exp ov=0 cnt=0000 src=000", ov3, cnt3, {s1_3, s2_3, s3_3});
      end
      or3 = 1'b1;
   endtask

   // Random codes and random out_ready on the size=8 instance, scoreboarded.
   task automatic test_random();
      logic [1:0] q [$];
      logic       ov_m = 1'b0;
      logic       acc, xf;
      logic [1:0] exp_c, got_c;
      int         transfers = 0;
      for (int i = 0; i < 1003; i++) begin
         @(negedge clk);
         if (i < 1000) begin
            iv8 = 1'($urandom_range(0, 1));
            or8 = ($urandom_range(0, 3) != 0);
         end else begin
            iv8 = 1'b0;
            or8 = 1'b1;
         end
         code8 = 2'($urandom_range(0, 3));
         #1;
         nvec++; if (ov8 !== ov_m) begin nerr++; $display("FAIL rand_out_valid[%0d] got %b exp %b", i, ov8, ov_m); end
         nvec++; if (ir8 !== (!ov_m || or8)) begin nerr++; $display("FAIL rand_in_ready[%0d] got %b exp %b", i, ir8, !ov_m || or8); end
         xf  = ov_m && or8;
         acc = iv8 && (!ov_m || or8);
         if (xf) begin
            exp_c = q.pop_front();
            got_c = lead_one(s1_8[0], s2_8[0], s3_8[0]);
            transfers++;
            nvec++; if (got_c !== exp_c) begin nerr++; $display("FAIL rand_decode[%0d] got %0d exp %0d", i, got_c, exp_c); end
`ifndef PRIO_CODE_EXPANDER_RANDFILL_EN
            nvec++; if ({s1_8[7:1], s2_8[7:1], s3_8[7:1]} !== 21'h0) begin
               nerr++; $display("FAIL rand_zero_fill[%0d] got %h_%h_%h exp upper bits 0", i, s1_8, s2_8, s3_8);
            end
`endif
         end
         if (acc) q.push_back(code8);
         ov_m = acc ? 1'b1 : (xf ? 1'b0 : ov_m);
      end
      @(negedge clk);
      nvec++; if (cnt8 !== 16'(transfers)) begin nerr++; $display("FAIL rand_count got %0d exp %0d", cnt8, transfers); end
   endtask

   // 65536 transfers wrap count back to zero.
   task automatic test_count_wrap();
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      iv3 = 1'b1; or3 = 1'b1; code3 = 2'd3;
      repeat (65536) @(negedge clk);
      nvec++; if (cnt3 !== 16'hFFFF) begin nerr++; $display("FAIL wrap_pre got %h exp FFFF", cnt3); end
      iv3 = 1'b0;
      @(negedge clk);
      nvec++; if (cnt3 !== 16'h0000 || ov3 !== 1'b0) begin nerr++; $display("FAIL wrap_zero got cnt=%h ov=%b exp cnt=0000 ov=0", cnt3, ov3); end
   endtask

   initial begin
      reset = 1'b1;
      iv3 = 1'b0; or3 = 1'b1; code3 = 2'd0;
      iv8 = 1'b0; or8 = 1'b1; code8 = 2'd0;
      test_reset();
      test_back_to_back();
      test_backpressure();
      test_reset_mid();
      test_random();
      test_count_wrap();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
